// File: rtl/stage_memory.sv
// Memory pipeline stage: passes ALU results, runs one bus load/store per mem slot.
// Ports: stall in/out, execute slot in, valid/ready data bus, fwd + registered wb out.
// Optional MEM_ALIGN_CHECK_EN: misaligned mem slots fault instead of using the bus.
module stage_memory #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_in,
  output logic               stall,
  input  logic [RADDR_W-1:0] in_dest,
  input  logic [XLEN-1:0]    in_val,
  input  logic               in_is_mem,
  input  logic               in_mem_write,
  input  logic [XLEN-1:0]    in_mem_addr,
  input  logic [XLEN-1:0]    in_mem_wdata,
  output logic               bus_req,
  output logic               bus_we,
  output logic [XLEN-1:0]    bus_addr,
  output logic [XLEN-1:0]    bus_wdata,
  input  logic               bus_ready,
  input  logic               bus_rvalid,
  input  logic [XLEN-1:0]    bus_rdata,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_addr,
  output logic [XLEN-1:0]    fwd_val,
  output logic [RADDR_W-1:0] out_addr,
  output logic [XLEN-1:0]    out_val,
  output logic               misalign
);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [XLEN-1:0]    addr_q, addr_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;
  logic               we_q, we_d;
  logic [RADDR_W-1:0] dest_q, dest_d;
  logic [XLEN-1:0]    rdata_q, rdata_d;
  logic [RADDR_W-1:0] out_addr_q, out_addr_d;
  logic [XLEN-1:0]    out_val_q, out_val_d;
  logic               misalign_q, misalign_d;
  logic               misaligned;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = in_mem_addr[1:0] != 2'b00;
`else
  assign misaligned = 1'b0;
`endif

  assign stall     = stall_in | (state_q != IDLE);
  assign bus_req   = state_q == REQ;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign out_addr  = out_addr_q;
  assign out_val   = out_val_q;
  assign misalign  = misalign_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    dest_d     = dest_q;
    rdata_d    = rdata_q;
    out_addr_d = '0;
    out_val_d  = '0;
    misalign_d = 1'b0;
    fwd_valid  = 1'b0;
    fwd_addr   = '0;
    fwd_val    = '0;
    unique case (state_q)
      IDLE: begin
        if (!in_is_mem) begin
          fwd_valid = in_dest != '0;
          fwd_addr  = in_dest;
          fwd_val   = in_val;
          if (!stall_in) begin
            out_addr_d = in_dest;
            out_val_d  = in_val;
          end
        end else if (!stall_in) begin
          if (misaligned) begin
            misalign_d = 1'b1;
          end else begin
            addr_d  = in_mem_addr;
            wdata_d = in_mem_wdata;
            we_d    = in_mem_write;
            dest_d  = in_dest;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (bus_ready) begin
          state_d = we_q ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (bus_rvalid) begin
          rdata_d = bus_rdata;
          if (!stall_in) begin
            fwd_valid  = dest_q != '0;
            fwd_addr   = dest_q;
            fwd_val    = bus_rdata;
            out_addr_d = dest_q;
            out_val_d  = bus_rdata;
            state_d    = IDLE;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (!stall_in) begin
          fwd_valid  = dest_q != '0;
          fwd_addr   = dest_q;
          fwd_val    = rdata_q;
          out_addr_d = dest_q;
          out_val_d  = rdata_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      dest_q     <= '0;
      rdata_q    <= '0;
      out_addr_q <= '0;
      out_val_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      dest_q     <= dest_d;
      rdata_q    <= rdata_d;
      out_addr_q <= out_addr_d;
      out_val_q  <= out_val_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_stage_memory.sv
// Scoreboard bench for stage_memory: bus, forward and writeback queues.
module tb_stage_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        stall;
  logic [3:0]  in_dest;
  logic [31:0] in_val;
  logic        in_is_mem;
  logic        in_mem_write;
  logic [31:0] in_mem_addr;
  logic [31:0] in_mem_wdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        fwd_valid;
  logic [3:0]  fwd_addr;
  logic [31:0] fwd_val;
  logic [3:0]  out_addr;
  logic [31:0] out_val;
  logic        misalign;

  stage_memory dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .stall(stall),
    .in_dest(in_dest), .in_val(in_val), .in_is_mem(in_is_mem),
    .in_mem_write(in_mem_write), .in_mem_addr(in_mem_addr),
    .in_mem_wdata(in_mem_wdata), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_val(fwd_val),
    .out_addr(out_addr), .out_val(out_val), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int req_cycles = 0;
  int mis_cycles = 0;

  logic [64:0] bus_q[$];
  logic [35:0] fwd_q[$];
  logic [35:0] wb_q[$];

  task automatic check(input string name,
                       input logic [95:0] act,
                       input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [95:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got %h expected nothing", name, act);
  endtask

  // Monitor: pop expected responses whenever the DUT presents one.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_req) req_cycles++;
      if (misalign) mis_cycles++;
      if (bus_req && bus_ready) begin
        if (bus_q.size() == 0)
          unexpected("bus_xfer", {31'd0, bus_we, bus_addr, bus_wdata});
        else
          check("bus_xfer", {31'd0, bus_we, bus_addr, bus_wdata},
                {31'd0, bus_q.pop_front()});
      end
      if (fwd_valid) begin
        if (fwd_q.size() == 0)
          unexpected("fwd", {60'd0, fwd_addr, fwd_val});
        else
          check("fwd", {60'd0, fwd_addr, fwd_val},
                {60'd0, fwd_q.pop_front()});
      end
      if (out_addr != 4'd0) begin
        if (wb_q.size() == 0)
          unexpected("wb", {60'd0, out_addr, out_val});
        else
          check("wb", {60'd0, out_addr, out_val},
                {60'd0, wb_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    in_dest      = 4'd0;
    in_val       = 32'd0;
    in_is_mem    = 1'b0;
    in_mem_write = 1'b0;
    in_mem_addr  = 32'd0;
    in_mem_wdata = 32'd0;
  endtask

  task automatic mem_slot(input logic we, input logic [3:0] d,
                          input logic [31:0] a, input logic [31:0] wd);
    in_is_mem    = 1'b1;
    in_mem_write = we;
    in_dest      = d;
    in_mem_addr  = a;
    in_mem_wdata = wd;
    in_val       = 32'h1111_1111;
  endtask

  int r0;

  initial begin
    rst = 1'b1;
    stall_in = 1'b0;
    bus_ready = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata = 32'd0;
    clr();
    tick();
    tick();
    @(negedge clk);
    check("rst_out_addr", {92'd0, out_addr}, 96'd0);
    check("rst_out_val", {64'd0, out_val}, 96'd0);
    check("rst_bus_req", {95'd0, bus_req}, 96'd0);
    check("rst_misalign", {95'd0, misalign}, 96'd0);
    tick();
    rst = 1'b0;
    tick();

    // 1: ALU slot
    in_dest = 4'd3;
    in_val  = 32'h1234;
    fwd_q.push_back({4'd3, 32'h1234});
    wb_q.push_back({4'd3, 32'h1234});
    @(negedge clk);
    check("t1_stall", {95'd0, stall}, 96'd0);
    tick();
    clr();
    tick();

    // 2: load, ready on 2nd REQ cycle, rvalid 3 cycles into WAIT
    r0 = req_cycles;
    mem_slot(1'b0, 4'd5, 32'h100, 32'd0);
    bus_q.push_back({1'b0, 32'h100, 32'd0});
    fwd_q.push_back({4'd5, 32'hCAFE_F00D});
    wb_q.push_back({4'd5, 32'hCAFE_F00D});
    tick();
    clr();
    @(negedge clk);
    check("t2_stall_req", {95'd0, stall}, 96'd1);
    tick();
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    @(negedge clk);
    check("t2_stall_wait", {95'd0, stall}, 96'd1);
    tick();
    tick();
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hCAFE_F00D;
    tick();
    bus_rvalid = 1'b0;
    bus_rdata  = 32'd0;
    @(negedge clk);
    check("t2_stall_done", {95'd0, stall}, 96'd0);
    tick();
    check("t2_req_cycles", 96'(req_cycles - r0), 96'd2);

    // 3: store, ready immediately
    r0 = req_cycles;
    mem_slot(1'b1, 4'd7, 32'h200, 32'hDEAD_BEEF);
    bus_q.push_back({1'b1, 32'h200, 32'hDEAD_BEEF});
    tick();
    clr();
    bus_ready = 1'b1;
    @(negedge clk);
    check("t3_stall_req", {95'd0, stall}, 96'd1);
    tick();
    bus_ready = 1'b0;
    @(negedge clk);
    check("t3_stall_rel", {95'd0, stall}, 96'd0);
    check("t3_out_addr", {92'd0, out_addr}, 96'd0);
    tick();
    check("t3_req_cycles", 96'(req_cycles - r0), 96'd1);

    // 4: load completes under downstream stall
    mem_slot(1'b0, 4'd9, 32'h300, 32'd0);
    bus_q.push_back({1'b0, 32'h300, 32'd0});
    fwd_q.push_back({4'd9, 32'h55AA_1234});
    wb_q.push_back({4'd9, 32'h55AA_1234});
    tick();
    clr();
    bus_ready = 1'b1;
    tick();
    bus_ready  = 1'b0;
    stall_in   = 1'b1;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h55AA_1234;
    @(negedge clk);
    check("t4_fwd_wait", {95'd0, fwd_valid}, 96'd0);
    tick();
    bus_rvalid = 1'b0;
    bus_rdata  = 32'h0BAD_0BAD;
    @(negedge clk);
    check("t4_fwd_hold1", {95'd0, fwd_valid}, 96'd0);
    check("t4_stall_hold", {95'd0, stall}, 96'd1);
    tick();
    @(negedge clk);
    check("t4_fwd_hold2", {95'd0, fwd_valid}, 96'd0);
    tick();
    stall_in = 1'b0;
    tick();
    tick();

    // 5a: reset during REQ drops bus_req at once
    mem_slot(1'b0, 4'd6, 32'h400, 32'd0);
    tick();
    clr();
    #2;
    rst = 1'b1;
    #1;
    check("t5_req_async", {95'd0, bus_req}, 96'd0);
    check("t5_stall_async", {95'd0, stall}, 96'd0);
    tick();
    rst = 1'b0;
    tick();

    // 5b: reset in WAIT, then stray rvalid
    mem_slot(1'b0, 4'd6, 32'h400, 32'd0);
    bus_q.push_back({1'b0, 32'h400, 32'd0});
    tick();
    clr();
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("t5_wait_req", {95'd0, bus_req}, 96'd0);
    check("t5_wait_stall", {95'd0, stall}, 96'd0);
    tick();
    rst = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h7777_7777;
    tick();
    bus_rvalid = 1'b0;
    bus_rdata  = 32'd0;
    @(negedge clk);
    check("t5_out_addr", {92'd0, out_addr}, 96'd0);
    check("t5_out_val", {64'd0, out_val}, 96'd0);
    tick();

    // 6: misaligned load
    r0 = req_cycles;
    mem_slot(1'b0, 4'd4, 32'h102, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
    tick();
    clr();
    @(negedge clk);
    check("t6_misalign", {95'd0, misalign}, 96'd1);
    check("t6_bus_req", {95'd0, bus_req}, 96'd0);
    check("t6_stall", {95'd0, stall}, 96'd0);
    tick();
    @(negedge clk);
    check("t6_mis_pulse", {95'd0, misalign}, 96'd0);
    check("t6_out_addr", {92'd0, out_addr}, 96'd0);
    tick();
    check("t6_req_cycles", 96'(req_cycles - r0), 96'd0);
    check("t6_mis_cycles", 96'(mis_cycles), 96'd1);
`else
    bus_q.push_back({1'b0, 32'h102, 32'd0});
    fwd_q.push_back({4'd4, 32'h0BAD_F00D});
    wb_q.push_back({4'd4, 32'h0BAD_F00D});
    tick();
    clr();
    @(negedge clk);
    check("t6_bus_addr", {64'd0, bus_addr}, {64'd0, 32'h102});
    check("t6_bus_req", {95'd0, bus_req}, 96'd1);
    bus_ready = 1'b1;
    tick();
    bus_ready  = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h0BAD_F00D;
    tick();
    bus_rvalid = 1'b0;
    bus_rdata  = 32'd0;
    tick();
    check("t6_req_cycles", 96'(req_cycles - r0), 96'd1);
    check("t6_mis_cycles", 96'(mis_cycles), 96'd0);
`endif

    tick();
    tick();
    check("bus_q_left", 96'(bus_q.size()), 96'd0);
    check("fwd_q_left", 96'(fwd_q.size()), 96'd0);
    check("wb_q_left", 96'(wb_q.size()), 96'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
